// File: rtl/vdma_video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vdma_video_pkg                                                       |
// | Shared crop-stage state encodings and RGB565 packing helpers.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vdma_video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_DONE    = 2'd3
    } crop_state_t;

    localparam int R_MSB          = 23;
    localparam int R_LSB          = 19;
    localparam int G_MSB          = 15;
    localparam int G_LSB          = 10;
    localparam int B_MSB          = 7;
    localparam int B_LSB          = 3;
    localparam int LINE_START_BIT = 16;

    localparam logic [11:0] CNT_MAX = 12'hFFF;

    function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
        return {rgb[R_MSB:R_LSB], rgb[G_MSB:G_LSB], rgb[B_MSB:B_LSB]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_generator                                                       |
// | One-cycle rise/fall strobes of a level signal relative to last clk.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module edge_generator (
    input  logic pclk,
    input  logic prst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_q;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

endmodule
`default_nettype wire

// File: rtl/video_crop_rgb565_in.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_crop_rgb565_in                                                 |
// | Crops a raw RGB888 stream to a window and packs it to RGB565.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module video_crop_rgb565_in
    import vdma_video_pkg::*;
#(
    parameter string VS_ACTIVE_HIGH = "TRUE"
) (
    input  logic        pclk,
    input  logic        prst_n,
    input  logic        in_vsync,
    input  logic        in_de,
    input  logic [23:0] in_rgb,
    input  logic        cfg_enable,
    input  logic [11:0] cfg_x_start,
    input  logic [11:0] cfg_y_start,
    input  logic [11:0] cfg_width,
    input  logic [11:0] cfg_height,
    output logic        vsync,
    output logic        de,
    output logic [16:0] indata,
    output logic [23:0] video_width,
    output logic [11:0] video_height,
    output logic        crop_error
);

    localparam bit VS_INVERT = (VS_ACTIVE_HIGH == "FALSE");

    logic        vs_norm;
    logic        vs_rise;
    logic        vs_fall;
    logic        de_rise;
    logic        de_fall;

    logic        sh_enable;
    logic [11:0] sh_x_start;
    logic [11:0] sh_y_start;
    logic [11:0] sh_width;
    logic [11:0] sh_height;

    crop_state_t state;
    logic [11:0] xcnt;
    logic [11:0] ycnt;
    logic [11:0] px_cnt;
    logic [11:0] line_cnt;
    logic        short_line;
    logic        line_fwd;

    logic [12:0] x_end;
    logic [12:0] y_end;
    logic        in_x;
    logic        in_y;
    logic        row_last;
    logic        fwd;
    logic        first;

    logic        s1_vs;
    logic        s1_de;
    logic [16:0] s1_data;

    assign vs_norm = VS_INVERT ? ~in_vsync : in_vsync;

    edge_generator u_vs_edge (
        .pclk   (pclk),
        .prst_n (prst_n),
        .din    (vs_norm),
        .rise   (vs_rise),
        .fall   (vs_fall)
    );

    edge_generator u_de_edge (
        .pclk   (pclk),
        .prst_n (prst_n),
        .din    (in_de),
        .rise   (de_rise),
        .fall   (de_fall)
    );

    // 13-bit window bounds so x_start+width never wraps into a false match
    assign x_end    = {1'b0, sh_x_start} + {1'b0, sh_width};
    assign y_end    = {1'b0, sh_y_start} + {1'b0, sh_height};
    assign in_x     = (xcnt >= sh_x_start) && ({1'b0, xcnt} < x_end);
    assign in_y     = (ycnt >= sh_y_start) && ({1'b0, ycnt} < y_end);
    assign row_last = ({1'b0, ycnt} == (y_end - 13'd1));
    assign fwd      = (state == ST_ACTIVE) && in_de && !vs_norm && in_x && in_y;
    assign first    = fwd && (de_rise || !line_fwd);

    assign video_width  = {12'd0, sh_width};
    assign video_height = sh_height;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            sh_enable  <= 1'b0;
            sh_x_start <= 12'd0;
            sh_y_start <= 12'd0;
            sh_width   <= 12'd0;
            sh_height  <= 12'd0;
        end else if (vs_norm) begin
            sh_enable  <= cfg_enable;
            sh_x_start <= cfg_x_start;
            sh_y_start <= cfg_y_start;
            sh_width   <= cfg_width;
            sh_height  <= cfg_height;
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            xcnt <= 12'd0;
            ycnt <= 12'd0;
        end else begin
            if (vs_norm || de_fall) begin
                xcnt <= 12'd0;
            end else if (in_de && xcnt != CNT_MAX) begin
                xcnt <= xcnt + 12'd1;
            end
            if (vs_norm) begin
                ycnt <= 12'd0;
            end else if (de_fall && ycnt != CNT_MAX) begin
                ycnt <= ycnt + 12'd1;
            end
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state <= ST_IDLE;
        end else if (vs_norm && !sh_enable) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sh_enable) state <= ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    if (vs_fall && sh_width != 12'd0 && sh_height != 12'd0) state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    // A frame that ends before the window is complete restarts cleanly
                    if (vs_rise) state <= ST_WAIT_VS;
                    else if (de_fall && row_last) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (vs_rise) state <= ST_WAIT_VS;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            px_cnt     <= 12'd0;
            line_cnt   <= 12'd0;
            short_line <= 1'b0;
            line_fwd   <= 1'b0;
            crop_error <= 1'b0;
        end else begin
            if (vs_norm) begin
                px_cnt   <= 12'd0;
                line_fwd <= 1'b0;
            end else if (de_rise) begin
                px_cnt   <= fwd ? 12'd1 : 12'd0;
                line_fwd <= fwd;
            end else if (fwd) begin
                line_fwd <= 1'b1;
                if (px_cnt != CNT_MAX) px_cnt <= px_cnt + 12'd1;
            end

            if (vs_norm) begin
                line_cnt   <= 12'd0;
                short_line <= 1'b0;
            end else if (de_fall && state == ST_ACTIVE && in_y) begin
                if (line_cnt != CNT_MAX) line_cnt <= line_cnt + 12'd1;
                if (px_cnt != sh_width) short_line <= 1'b1;
            end

            // Judged against the shadow window of the frame just finished
            if (vs_rise) begin
                if (state == ST_IDLE) begin
                    crop_error <= 1'b0;
                end else begin
                    crop_error <= short_line || (line_cnt != sh_height) ||
                                  (sh_width == 12'd0) || (sh_height == 12'd0);
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            s1_vs   <= 1'b0;
            s1_de   <= 1'b0;
            s1_data <= 17'd0;
            vsync   <= 1'b0;
            de      <= 1'b0;
            indata  <= 17'd0;
        end else begin
            s1_vs   <= vs_norm;
            s1_de   <= fwd;
            s1_data <= fwd ? {first, rgb888_to_565(in_rgb)} : 17'd0;
            vsync   <= s1_vs;
            de      <= s1_de;
            indata  <= s1_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_crop_rgb565_in.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_video_crop_rgb565_in                                              |
// | Scoreboard bench for the crop/RGB565 input stage on small frames.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_video_crop_rgb565_in;

    localparam int PPL    = 32;
    localparam int LINES  = 8;
    localparam int HBLANK = 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [16:0] data;
    } px_t;

    logic        pclk = 1'b0;
    logic        prst_n = 1'b0;
    logic        in_vsync = 1'b0;
    logic        in_de = 1'b0;
    logic [23:0] in_rgb = 24'd0;
    logic        cfg_enable = 1'b0;
    logic [11:0] cfg_x_start = 12'd0;
    logic [11:0] cfg_y_start = 12'd0;
    logic [11:0] cfg_width = 12'd0;
    logic [11:0] cfg_height = 12'd0;
    logic        vsync;
    logic        de;
    logic [16:0] indata;
    logic [23:0] video_width;
    logic [11:0] video_height;
    logic        crop_error;

    int          checks = 0;
    int          errors = 0;
    int          idle_bad = 0;
    logic [31:0] cyc = 32'd0;
    px_t         exp_q[$];
    px_t         got_q[$];
    px_t         mon_px;

    video_crop_rgb565_in #(.VS_ACTIVE_HIGH("TRUE")) dut (
        .pclk         (pclk),
        .prst_n       (prst_n),
        .in_vsync     (in_vsync),
        .in_de        (in_de),
        .in_rgb       (in_rgb),
        .cfg_enable   (cfg_enable),
        .cfg_x_start  (cfg_x_start),
        .cfg_y_start  (cfg_y_start),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .vsync        (vsync),
        .de           (de),
        .indata       (indata),
        .video_width  (video_width),
        .video_height (video_height),
        .crop_error   (crop_error)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 32'd1;

    always @(negedge pclk) begin
        if (prst_n) begin
            if (de) begin
                mon_px.cyc  = cyc;
                mon_px.data = indata;
                got_q.push_back(mon_px);
            end else if (indata !== 17'd0) begin
                idle_bad = idle_bad + 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_cfg(input logic en, input int xs, input int ys, input int w, input int h);
        cfg_enable  = en;
        cfg_x_start = 12'(xs);
        cfg_y_start = 12'(ys);
        cfg_width   = 12'(w);
        cfg_height  = 12'(h);
    endtask

    task automatic vsync_pulse();
        tick(); in_de = 1'b0; in_vsync = 1'b1;
        repeat (3) tick();
        tick(); in_vsync = 1'b0;
        repeat (3) tick();
    endtask

    // Drives a frame body and pushes every pixel the window should let through
    task automatic drive_lines(input int nlines, input bit expect_on, input int xs, input int ys,
                               input int w, input int h, input bit use_const, input logic [23:0] crgb);
        logic [23:0] rgb;
        px_t         e;
        for (int r = 0; r < nlines; r++) begin
            for (int c = 0; c < PPL; c++) begin
                tick();
                rgb    = use_const ? crgb : 24'($urandom);
                in_de  = 1'b1;
                in_rgb = rgb;
                if (expect_on && c >= xs && c < xs + w && r >= ys && r < ys + h) begin
                    e.cyc  = cyc + 32'd2;
                    e.data = {(c == xs), rgb[23:19], rgb[15:10], rgb[7:3]};
                    exp_q.push_back(e);
                end
            end
            repeat (HBLANK) begin
                tick();
                in_de = 1'b0;
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge pclk);
        #1;
        checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync got=%b exp=0", vsync); end
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de got=%b exp=0", de); end
        checks++; if (indata !== 17'd0) begin errors++; $display("FAIL reset_indata got=%h exp=0", indata); end
        checks++; if (crop_error !== 1'b0) begin errors++; $display("FAIL reset_crop_error got=%b exp=0", crop_error); end
        checks++; if (video_width !== 24'd0) begin errors++; $display("FAIL reset_width got=%0d exp=0", video_width); end
        checks++; if (video_height !== 12'd0) begin errors++; $display("FAIL reset_height got=%0d exp=0", video_height); end
        prst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_full_window();
        px_t e, g;
        set_cfg(1'b1, 0, 0, PPL, LINES);
        tick(); in_vsync = 1'b1;
        tick();
        checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL full_vs_lat1 got=%b exp=0", vsync); end
        checks++; if (video_width !== 24'(PPL)) begin errors++; $display("FAIL full_width got=%0d exp=%0d", video_width, PPL); end
        tick();
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL full_vs_lat2 got=%b exp=1", vsync); end
        tick();
        checks++; if (video_height !== 12'(LINES)) begin errors++; $display("FAIL full_height got=%0d exp=%0d", video_height, LINES); end
        tick(); in_vsync = 1'b0;
        repeat (3) tick();
        drive_lines(LINES, 1'b1, 0, 0, PPL, LINES, 1'b0, 24'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL full_px got=none exp=%h@%0d", e.data, e.cyc);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin errors++; $display("FAIL full_px got=%h@%0d exp=%h@%0d", g.data, g.cyc, e.data, e.cyc); end
            end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL full_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_crop_window();
        px_t e, g;
        set_cfg(1'b1, 10, 3, 16, 5);
        vsync_pulse();
        checks++; if (crop_error !== 1'b0) begin errors++; $display("FAIL crop_err_prev got=%b exp=0", crop_error); end
        checks++; if (video_width !== 24'd16) begin errors++; $display("FAIL crop_width got=%0d exp=16", video_width); end
        set_cfg(1'b1, 0, 0, PPL, LINES);
        drive_lines(LINES, 1'b1, 10, 3, 16, 5, 1'b1, 24'hFF8040);
        checks++; if (video_width !== 24'd16) begin errors++; $display("FAIL crop_width_hold got=%0d exp=16", video_width); end
        checks++;
        if (got_q.size() == 0 || got_q[0].data !== 17'h1FC08) begin
            errors++; $display("FAIL crop_first got=%h exp=1fc08", (got_q.size() == 0) ? 17'd0 : got_q[0].data);
        end
        checks++;
        if (got_q.size() < 2 || got_q[1].data !== 17'h0FC08) begin
            errors++; $display("FAIL crop_second got=%h exp=0fc08", (got_q.size() < 2) ? 17'd0 : got_q[1].data);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL crop_px got=none exp=%h@%0d", e.data, e.cyc);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin errors++; $display("FAIL crop_px got=%h@%0d exp=%h@%0d", g.data, g.cyc, e.data, e.cyc); end
            end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL crop_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
        set_cfg(1'b1, 10, 3, 16, 5);
    endtask

    task automatic test_partial();
        px_t e, g;
        set_cfg(1'b1, 24, 0, 16, LINES);
        vsync_pulse();
        checks++; if (crop_error !== 1'b0) begin errors++; $display("FAIL part_err_prev got=%b exp=0", crop_error); end
        drive_lines(LINES, 1'b1, 24, 0, 16, LINES, 1'b0, 24'd0);
        checks++;
        if (exp_q.size() != 8 * LINES) begin errors++; $display("FAIL part_count got=%0d exp=%0d", exp_q.size(), 8 * LINES); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL part_px got=none exp=%h@%0d", e.data, e.cyc);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin errors++; $display("FAIL part_px got=%h@%0d exp=%h@%0d", g.data, g.cyc, e.data, e.cyc); end
            end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL part_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
        set_cfg(1'b1, 0, 0, PPL, LINES);
        vsync_pulse();
        checks++; if (crop_error !== 1'b1) begin errors++; $display("FAIL part_err got=%b exp=1", crop_error); end
        drive_lines(LINES, 1'b1, 0, 0, PPL, LINES, 1'b0, 24'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL part_full_px got=none exp=%h@%0d", e.data, e.cyc);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin errors++; $display("FAIL part_full_px got=%h@%0d exp=%h@%0d", g.data, g.cyc, e.data, e.cyc); end
            end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL part_full_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_zero_width();
        set_cfg(1'b1, 0, 0, 0, LINES);
        vsync_pulse();
        checks++; if (crop_error !== 1'b0) begin errors++; $display("FAIL zw_err_clear got=%b exp=0", crop_error); end
        checks++; if (video_width !== 24'd0) begin errors++; $display("FAIL zw_width got=%0d exp=0", video_width); end
        drive_lines(LINES, 1'b0, 0, 0, 0, LINES, 1'b0, 24'd0);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL zw_de got=%0d exp=0", got_q.size()); got_q.delete(); end
        set_cfg(1'b1, 0, 0, PPL, LINES);
        vsync_pulse();
        checks++; if (crop_error !== 1'b1) begin errors++; $display("FAIL zw_err got=%b exp=1", crop_error); end
    endtask

    task automatic test_enable();
        px_t e, g;
        set_cfg(1'b0, 0, 0, PPL, LINES);
        vsync_pulse();
        drive_lines(LINES / 2, 1'b0, 0, 0, PPL, LINES, 1'b0, 24'd0);
        cfg_enable = 1'b1;
        drive_lines(LINES / 2, 1'b0, 0, 0, PPL, LINES, 1'b0, 24'd0);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL en_off_de got=%0d exp=0", got_q.size()); got_q.delete(); end
        vsync_pulse();
        drive_lines(LINES, 1'b1, 0, 0, PPL, LINES, 1'b0, 24'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL en_px got=none exp=%h@%0d", e.data, e.cyc);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin errors++; $display("FAIL en_px got=%h@%0d exp=%h@%0d", g.data, g.cyc, e.data, e.cyc); end
            end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL en_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_collision();
        px_t e, g;
        set_cfg(1'b1, 2, 1, 20, 6);
        tick(); in_vsync = 1'b1; in_de = 1'b1; in_rgb = 24'h123456;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dut.xcnt !== 12'd0) begin errors++; $display("FAIL coll_xcnt got=%0d exp=0", dut.xcnt); end
        end
        in_de = 1'b0;
        tick(); in_vsync = 1'b0;
        repeat (5) tick();
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL coll_de got=%0d exp=0", got_q.size()); got_q.delete(); end
        drive_lines(LINES, 1'b1, 2, 1, 20, 6, 1'b0, 24'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL coll_px got=none exp=%h@%0d", e.data, e.cyc);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin errors++; $display("FAIL coll_px got=%h@%0d exp=%h@%0d", g.data, g.cyc, e.data, e.cyc); end
            end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL coll_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_reset_mid();
        px_t e, g;
        set_cfg(1'b1, 0, 0, PPL, LINES);
        vsync_pulse();
        for (int c = 0; c < 10; c++) begin
            tick(); in_de = 1'b1; in_rgb = 24'($urandom);
        end
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_de got=%b exp=1", de); end
        @(posedge pclk);
        #3 prst_n = 1'b0;
        #1;
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL rst_mid_de got=%b exp=0", de); end
        checks++; if (indata !== 17'd0) begin errors++; $display("FAIL rst_mid_indata got=%h exp=0", indata); end
        checks++; if (video_width !== 24'd0) begin errors++; $display("FAIL rst_mid_width got=%0d exp=0", video_width); end
        got_q.delete();
        repeat (2) tick();
        prst_n = 1'b1;
        for (int c = 12; c < PPL; c++) tick();
        repeat (HBLANK) begin tick(); in_de = 1'b0; end
        drive_lines(LINES - 1, 1'b0, 0, 0, PPL, LINES, 1'b0, 24'd0);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL rst_mid_de_after got=%0d exp=0", got_q.size()); got_q.delete(); end
        vsync_pulse();
        drive_lines(LINES, 1'b1, 0, 0, PPL, LINES, 1'b0, 24'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL rst_mid_px got=none exp=%h@%0d", e.data, e.cyc);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin errors++; $display("FAIL rst_mid_px got=%h@%0d exp=%h@%0d", g.data, g.cyc, e.data, e.cyc); end
            end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL rst_mid_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_idle_data();
        checks++;
        if (idle_bad != 0) begin errors++; $display("FAIL idle_indata got=%0d nonzero samples exp=0", idle_bad); end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_crop_window();
        test_partial();
        test_zero_width();
        test_enable();
        test_collision();
        test_reset_mid();
        test_idle_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
